// File: rtl/morse_pkg.sv
// morse_pkg: Morse timing unit multiples and controller state encoding.
package morse_pkg;
  localparam int DOT_UNITS        = 1;
  localparam int DASH_UNITS       = 3;
  localparam int SYM_GAP_UNITS    = 1;
  localparam int CHAR_GAP_UNITS   = 3;
  localparam int WORD_EXTRA_UNITS = 4;
  typedef enum logic [2:0] {IDLE, MARK, SYM_GAP, CHAR_GAP, WORD_GAP} state_e;
endpackage

// File: rtl/morse_tx_ctrl_if.sv
// morse_tx_ctrl_if: per-requester character handshake bundle.
interface morse_tx_ctrl_if #(
  parameter int N_REQ   = 2,
  parameter int MAX_SYM = 6
);
  localparam int LW = $clog2(MAX_SYM + 1);
  logic [N_REQ-1:0]         i_req_valid;
  logic [N_REQ-1:0]         o_req_ready;
  logic [N_REQ*LW-1:0]      i_req_len;
  logic [N_REQ*MAX_SYM-1:0] i_req_code;
  modport master (output i_req_valid, i_req_len, i_req_code, input o_req_ready);
  modport slave  (input i_req_valid, i_req_len, i_req_code, output o_req_ready);
endinterface

// File: rtl/morse_rr_arbiter.sv
// morse_rr_arbiter: round-robin grant starting after the last accepted index.
module morse_rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_valid,
  input  logic                     i_accept,
  output logic [N_REQ-1:0]         o_grant,
  output logic [$clog2(N_REQ)-1:0] o_idx
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] last_q, last_d;
  logic hit;
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    hit     = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!hit && i_valid[(int'(last_q) + i) % N_REQ]) begin
        hit = 1'b1;
        o_grant[(int'(last_q) + i) % N_REQ] = 1'b1;
        o_idx = IW'((int'(last_q) + i) % N_REQ);
      end
    end
    last_d = i_accept ? o_idx : last_q;
  end
  // Resetting to the last index makes requester 0 the first candidate.
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) last_q <= IW'(N_REQ - 1);
    else        last_q <= last_d;
endmodule

// File: rtl/morse_tx_ctrl.sv
// morse_tx_ctrl: arbitrates requesters and keys granted characters onto the
// Morse line with dot/dash/symbol/character/word unit timing.
module morse_tx_ctrl
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 4,
  parameter int MAX_SYM     = 6,
  parameter int N_REQ       = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  morse_tx_ctrl_if.slave           req,
  output logic                     o_data_morse,
  output logic                     o_busy,
  output logic [$clog2(N_REQ)-1:0] o_grant_id
);
  localparam int LW = $clog2(MAX_SYM + 1);
  localparam int UW = $clog2(4 * UNIT_CYCLES);
  localparam int GW = $clog2(N_REQ);
  localparam logic [UW-1:0] DOT_L  = UW'(DOT_UNITS * UNIT_CYCLES - 1);
  localparam logic [UW-1:0] DASH_L = UW'(DASH_UNITS * UNIT_CYCLES - 1);
  localparam logic [UW-1:0] SGAP_L = UW'(SYM_GAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [UW-1:0] CGAP_L = UW'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [UW-1:0] WGAP_L = UW'(WORD_EXTRA_UNITS * UNIT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [UW-1:0]        unit_q, unit_d;
  logic [LW-1:0]        sym_q, sym_d, len_in, len_c;
  logic [MAX_SYM-1:0]   code_q, code_d, code_in;
  logic                 data_q, data_d;
  logic [GW-1:0]        grant_q, grant_d, idx;
  logic [N_REQ-1:0]     gnt;
  logic                 accept;

  morse_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (req.i_req_valid),
    .i_accept (accept),
    .o_grant  (gnt),
    .o_idx    (idx)
  );

  assign req.o_req_ready = (state_q == IDLE) ? gnt : '0;
  assign accept  = (state_q == IDLE) && (|gnt);
  assign len_in  = req.i_req_len[int'(idx) * LW +: LW];
  assign code_in = req.i_req_code[int'(idx) * MAX_SYM +: MAX_SYM];
  assign len_c   = (int'(len_in) > MAX_SYM) ? LW'(MAX_SYM) : len_in;

  // Unit counter is loaded on each state entry and the state exits when it hits zero.
  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    sym_d   = sym_q;
    code_d  = code_q;
    grant_d = grant_q;
    if (state_q == IDLE) begin
      if (accept) begin
        grant_d = idx;
        code_d  = code_in;
        sym_d   = len_c;
        state_d = (len_c == '0) ? WORD_GAP : MARK;
        unit_d  = (len_c == '0) ? WGAP_L : (code_in[0] ? DASH_L : DOT_L);
      end
    end else if (unit_q != '0) begin
      unit_d = unit_q - UW'(1);
    end else if (state_q == MARK) begin
      sym_d   = sym_q - LW'(1);
      code_d  = code_q >> 1;
      state_d = (sym_q == LW'(1)) ? CHAR_GAP : SYM_GAP;
      unit_d  = (sym_q == LW'(1)) ? CGAP_L : SGAP_L;
    end else if (state_q == SYM_GAP) begin
      state_d = MARK;
      unit_d  = code_q[0] ? DASH_L : DOT_L;
    end else begin
      state_d = IDLE;
    end
    data_d = (state_d == MARK);
  end

  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      state_q <= IDLE;
      unit_q  <= '0;
      sym_q   <= '0;
      code_q  <= '0;
      data_q  <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      sym_q   <= sym_d;
      code_q  <= code_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end

  assign o_data_morse = data_q;
  assign o_busy       = (state_q != IDLE);
  assign o_grant_id   = grant_q;
endmodule

// File: tb/tb_morse_tx_ctrl.sv
// tb_morse_tx_ctrl: directed scenarios for timing, arbitration, reset and clamping.
module tb_morse_tx_ctrl;
  localparam int LW = 3;
  localparam int MS = 6;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data, busy, grant;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  morse_tx_ctrl_if #(.N_REQ(2), .MAX_SYM(MS)) rif();
  morse_tx_ctrl #(.UNIT_CYCLES(4), .MAX_SYM(MS), .N_REQ(2)) dut (
    .i_clk(clk), .i_rst(rst_n), .req(rif),
    .o_data_morse(data), .o_busy(busy), .o_grant_id(grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic set_req(input int k, input logic v, input logic [LW-1:0] l, input logic [MS-1:0] c);
    rif.i_req_valid[k] = v;
    rif.i_req_len[k*LW +: LW] = l;
    rif.i_req_code[k*MS +: MS] = c;
  endtask

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      #1;
      if (|(rif.i_req_valid & rif.o_req_ready)) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic capture(input int n, output logic [127:0] w, output logic [127:0] b);
    w = '0;
    b = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      w[i] = data;
      b[i] = busy;
    end
  endtask

  task automatic seg(inout logic [127:0] e, inout int p, input int n, input logic v);
    for (int i = 0; i < n; i++) begin
      e[p] = v;
      p++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    checks++; if (data !== 1'b0) begin failures++; $display("FAIL reset_data got=%b exp=0", data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (grant !== 1'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0", grant); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rif.o_req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready_idle got=%b exp=00", rif.o_req_ready); end
    set_req(0, 1'b1, 3'd1, 6'd0);
    set_req(1, 1'b1, 3'd1, 6'd0);
    #1;
    checks++; if (rif.o_req_ready !== 2'b01) begin failures++; $display("FAIL reset_priority got=%b exp=01", rif.o_req_ready); end
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_dot;
    bit ok;
    logic [127:0] w, b, e, eb;
    int p = 0;
    int q = 0;
    e = '0; eb = '0;
    seg(e, p, 4, 1'b1); seg(e, p, 12, 1'b0);
    seg(eb, q, 16, 1'b1);
    set_req(0, 1'b1, 3'd1, 6'b000000);
    wait_accept(ok);
    checks++; if (!ok) begin failures++; $display("FAIL dot_accept got=timeout exp=accept"); end
    capture(16, w, b);
    checks++; if (w !== e) begin failures++; $display("FAIL dot_wave got=%h exp=%h", w, e); end
    checks++; if (b !== eb) begin failures++; $display("FAIL dot_busy_wave got=%h exp=%h", b, eb); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || rif.o_req_ready !== 2'b01) begin
      failures++; $display("FAIL dot_end got=busy%b/ready%b exp=busy0/ready01", busy, rif.o_req_ready); end
    set_req(0, 1'b0, '0, '0);
  endtask

  task automatic test_dot_dash;
    bit ok;
    logic [127:0] w, b, e;
    int p = 0;
    e = '0;
    seg(e, p, 4, 1'b1); seg(e, p, 4, 1'b0); seg(e, p, 12, 1'b1); seg(e, p, 12, 1'b0);
    set_req(0, 1'b1, 3'd2, 6'b000010);
    wait_accept(ok);
    checks++; if (!ok) begin failures++; $display("FAIL a_accept got=timeout exp=accept"); end
    capture(32, w, b);
    checks++; if (w !== e) begin failures++; $display("FAIL a_wave got=%h exp=%h", w, e); end
    checks++; if (b[31:0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL a_busy_wave got=%h exp=ffffffff", b[31:0]); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || rif.o_req_ready !== 2'b01) begin
      failures++; $display("FAIL a_end got=busy%b/ready%b exp=busy0/ready01", busy, rif.o_req_ready); end
    set_req(0, 1'b0, '0, '0);
  endtask

  task automatic test_round_robin;
    bit ok;
    int t[4];
    rst_n = 1'b0;
    set_req(0, 1'b1, 3'd1, 6'b000000);
    set_req(1, 1'b1, 3'd1, 6'b000001);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_accept(ok);
      checks++; if (!ok) begin failures++; $display("FAIL rr_accept%0d got=timeout exp=accept", k); end
      t[k] = cyc;
      @(negedge clk);
      checks++; if (grant !== 1'(k % 2)) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%0d", k, grant, k % 2); end
    end
    checks++; if (t[1] - t[0] != 17 || t[2] - t[1] != 25 || t[3] - t[2] != 17) begin
      failures++; $display("FAIL rr_spacing got=%0d/%0d/%0d exp=17/25/17", t[1]-t[0], t[2]-t[1], t[3]-t[2]); end
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr_idle got=busy exp=idle"); end
  endtask

  task automatic test_word_gap;
    bit ok;
    logic [127:0] w, b;
    set_req(1, 1'b1, 3'd0, 6'd0);
    wait_accept(ok);
    checks++; if (!ok) begin failures++; $display("FAIL word_accept got=timeout exp=accept"); end
    capture(16, w, b);
    checks++; if (w !== '0) begin failures++; $display("FAIL word_wave got=%h exp=0", w); end
    checks++; if (b[15:0] !== 16'hFFFF) begin failures++; $display("FAIL word_busy_wave got=%h exp=ffff", b[15:0]); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || rif.o_req_ready !== 2'b10 || grant !== 1'b1) begin
      failures++; $display("FAIL word_end got=busy%b/ready%b/grant%b exp=busy0/ready10/grant1", busy, rif.o_req_ready, grant); end
    set_req(1, 1'b0, '0, '0);
  endtask

  task automatic test_reset_mid_dash;
    bit ok;
    set_req(0, 1'b1, 3'd1, 6'b000001);
    wait_accept(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rst_accept got=timeout exp=accept"); end
    @(posedge clk); #1;
    set_req(0, 1'b0, '0, '0);
    repeat (4) @(negedge clk);
    checks++; if (data !== 1'b1) begin failures++; $display("FAIL rst_mid_mark got=%b exp=1", data); end
    rst_n = 1'b0;
    #1;
    checks++; if (data !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_async got=data%b/busy%b exp=data0/busy0", data, busy); end
    set_req(0, 1'b1, 3'd1, 6'd0);
    set_req(1, 1'b1, 3'd1, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_accept(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rst_reaccept got=timeout exp=accept"); end
    @(negedge clk);
    checks++; if (grant !== 1'b0) begin failures++; $display("FAIL rst_first_grant got=%b exp=0", grant); end
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rst_idle got=busy exp=idle"); end
  endtask

  task automatic test_clamp;
    bit ok;
    logic [127:0] w, b, e;
    int p = 0;
    e = '0;
    for (int s = 0; s < 6; s++) begin
      seg(e, p, 12, 1'b1);
      if (s < 5) seg(e, p, 4, 1'b0);
    end
    seg(e, p, 12, 1'b0);
    set_req(0, 1'b1, 3'd7, 6'b111111);
    wait_accept(ok);
    checks++; if (!ok) begin failures++; $display("FAIL clamp_accept got=timeout exp=accept"); end
    capture(104, w, b);
    checks++; if (w !== e) begin failures++; $display("FAIL clamp_wave got=%h exp=%h", w, e); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || rif.o_req_ready !== 2'b01) begin
      failures++; $display("FAIL clamp_end got=busy%b/ready%b exp=busy0/ready01", busy, rif.o_req_ready); end
    set_req(0, 1'b0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_dot();
    test_dot_dash();
    test_round_robin();
    test_word_gap();
    test_reset_mid_dash();
    test_clamp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/morse_tx_ctrl.md
Name: morse_tx_ctrl

Overview:
- Sequencing controller for the single-wire Morse link that connects the sender and the receiver.
- Accepts characters from N_REQ requesters over valid/ready handshakes and arbitrates between them round-robin.
- Serialises each granted character onto o_data_morse with standard unit timing: dot, dash, symbol gap, character gap and word gap.
- Drives the same line the receiver samples, clocked by the shared i_clk.

Parameters:
- UNIT_CYCLES, 4, clock cycles per Morse time unit (≥1).
- MAX_SYM, 6, maximum symbols per character.
- N_REQ, 2, number of requesters (≥2).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_req_valid  in  N_REQ  per-requester character valid.
- o_req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- i_req_len  in  N_REQ*LW  per-requester symbol count, LW=$clog2(MAX_SYM+1); 0 = word space.
- i_req_code  in  N_REQ*MAX_SYM  per-requester symbols; bit0 sent first; 1=dash, 0=dot.
- o_data_morse  out  1  keyed Morse line, high = mark.
- o_busy  out  1  high whenever state ≠ IDLE.
- o_grant_id  out  max(1,$clog2(N_REQ))  index of last accepted requester.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - state=IDLE; o_data_morse=0; o_busy=0; o_grant_id=0.
  - rr pointer set so requester 0 has top priority.
  - counters cleared.
  - Mid-character reset aborts the character; o_data_morse drops immediately and nothing is resumed.
- States: IDLE, MARK, SYM_GAP, CHAR_GAP, WORD_GAP.
- IDLE:
  - Combinational round-robin grant among asserted i_req_valid, starting after the last granted index.
  - o_req_ready asserted only to the granted requester, and only in IDLE.
  - Transfer when valid&&ready in cycle T: latch len (clamped to MAX_SYM if larger) and code; update o_grant_id and rr pointer.
- Transfer in cycle T:
  - len≠0 → MARK from T+1, o_data_morse=1 from T+1.
  - len=0 → WORD_GAP from T+1.
- MARK: high for 1×UNIT_CYCLES (dot) or 3×UNIT_CYCLES (dash). Then SYM_GAP if symbols remain, else CHAR_GAP.
- SYM_GAP: low for 1 unit, then MARK with the next symbol (code shifted right).
- CHAR_GAP: low for 3 units, then IDLE.
- WORD_GAP: low for 4 units, then IDLE. Together with the preceding CHAR_GAP this gives the 7-unit word gap.
- Back-to-back operation: the earliest next transfer is the first IDLE cycle. No gap is inserted beyond CHAR_GAP/WORD_GAP.
- o_data_morse is registered and high only in MARK.
- Requester rules:
  - Requesters hold valid, len and code stable until ready.
  - Valid withdrawn before ready is legal and ignored.
  - Inputs from non-granted requesters are don't-care.
- Unit counter width: $clog2(4*UNIT_CYCLES). Counts down and never wraps; a load happens on every state entry.
- Symbol counter width LW; decrements at each MARK exit.

Decomposition:
- Package morse_pkg holds:
  - unit multiples DOT_UNITS=1, DASH_UNITS=3, SYM_GAP_UNITS=1, CHAR_GAP_UNITS=3, WORD_EXTRA_UNITS=4;
  - the state enum.
- Sub-module morse_rr_arbiter: N_REQ-wide round-robin grant with pointer update on an accept strobe.

Test Plan (UNIT_CYCLES=4):
1. req0 'E' (len=1, code=0) accepted at T → o_data_morse high T+1..T+4, low T+5..T+16; o_busy low and ready=1 at T+17.
2. req0 'A' (len=2, code=0b10) → high 4 cycles, low 4, high 12, low 12; next accept no earlier than T+33.
3. Both valid continuously from reset → grants 0,1,0,1 (o_grant_id sequence); each character is fully spaced with 12 low cycles.
4. req1 len=0 → o_data_morse low T+1..T+16, ready at T+17, o_grant_id=1.
5. i_rst low mid-dash → o_data_morse=0 and o_busy=0 asynchronously. After release with both requesters valid, requester 0 is granted first.
6. len=7 with MAX_SYM=6, code=0b111111 → exactly 6 dashes of 12 cycles each, separated by 4-cycle gaps, then a 12-cycle CHAR_GAP.
